cpm_stream_arb: RTL and testbench

CPM_STREAM_ARB -- requirements
Module: cpm_stream_arb

---
 rtl/cpm_stream_arb.sv | 104 ++++++++++
 tb/tb_cpm_stream_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpm_stream_arb.sv
// Merges N_PORTS single-beat streams into one registered output (round-robin or fixed priority); latency 1 cycle.
// Backpressure: out_ready=0 with a held beat freezes the output register and drops every in_ready.
module cpm_stream_arb #(
    parameter int N_PORTS    = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_PORTS-1:0]      in_valid,
    output logic [N_PORTS-1:0]      in_ready,
    input  logic [4*N_PORTS-1:0]    in_id,
    input  logic [4*N_PORTS-1:0]    in_opcode,
    input  logic [16*N_PORTS-1:0]   in_payload,
    input  logic [N_PORTS-1:0]      port_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_id,
    output logic [3:0]              out_opcode,
    output logic [15:0]             out_payload,
    output logic [2:0]              grant_idx,
    output logic [15:0]             hs_count
);

    typedef struct packed {
        logic [3:0]  id;
        logic [3:0]  opcode;
        logic [15:0] payload;
    } beat_t;

    logic               r_out_valid;
    beat_t              r_beat;
    logic [2:0]         r_grant_idx;
    logic [2:0]         r_rr_ptr;
    logic [15:0]        r_hs_count;

    logic               w_free;
    logic               w_found;
    logic [2:0]         w_win_idx;
    logic [2:0]         w_next_ptr;
    logic [N_PORTS-1:0] w_elig;
    beat_t              w_win_beat;

    assign w_free     = !r_out_valid || out_ready;
    assign w_elig     = in_valid & port_en;
    assign w_next_ptr = 3'((int'(w_win_idx) + 1) % N_PORTS);

    // Search starts at the pointer in round-robin mode, at port 0 in fixed-priority mode.
    always_comb begin
        int k;
        k          = 0;
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_win_beat = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            k = (FIXED_PRIO != 0) ? i : (int'(r_rr_ptr) + i) % N_PORTS;
            if (!w_found && w_elig[k]) begin
                w_found            = 1'b1;
                w_win_idx          = 3'(k);
                w_win_beat.id      = in_id[4*k +: 4];
                w_win_beat.opcode  = in_opcode[4*k +: 4];
                w_win_beat.payload = in_payload[16*k +: 16];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            in_ready[i] = rst && w_free && w_found && (w_win_idx == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_beat      <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_hs_count  <= '0;
        end else begin
            if (w_free) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_beat      <= w_win_beat;
                    r_grant_idx <= w_win_idx;
                    if (FIXED_PRIO == 0) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                end
            end
            if (r_out_valid && out_ready) begin
                r_hs_count <= r_hs_count + 16'd1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_id      = r_beat.id;
    assign out_opcode  = r_beat.opcode;
    assign out_payload = r_beat.payload;
    assign grant_idx   = r_grant_idx;
    assign hs_count    = r_hs_count;

endmodule

// File: tb/tb_cpm_stream_arb.sv
// Directed bench: a round-robin and a fixed-priority instance driven from shared inputs.
module tb_cpm_stream_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  port_en;
    logic [15:0] in_id;
    logic [15:0] in_opcode;
    logic [63:0] in_payload;
    logic        out_ready;

    logic [3:0]  rr_in_ready, fp_in_ready;
    logic        rr_out_valid, fp_out_valid;
    logic [3:0]  rr_out_id, fp_out_id;
    logic [3:0]  rr_out_opcode, fp_out_opcode;
    logic [15:0] rr_out_payload, fp_out_payload;
    logic [2:0]  rr_grant_idx, fp_grant_idx;
    logic [15:0] rr_hs_count, fp_hs_count;

    int tests  = 0;
    int failed = 0;

    logic [3:0]  e_id  [4] = '{4'h0, 4'h1, 4'h5, 4'h3};
    logic [3:0]  e_op  [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
    logic [15:0] e_pay [4] = '{16'hA000, 16'hA001, 16'hBEEF, 16'hA003};

    always #5 clk = ~clk;

    cpm_stream_arb #(.N_PORTS(4), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready),
        .in_id(in_id), .in_opcode(in_opcode), .in_payload(in_payload), .port_en(port_en),
        .out_valid(rr_out_valid), .out_ready(out_ready), .out_id(rr_out_id),
        .out_opcode(rr_out_opcode), .out_payload(rr_out_payload),
        .grant_idx(rr_grant_idx), .hs_count(rr_hs_count)
    );

    cpm_stream_arb #(.N_PORTS(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fp_in_ready),
        .in_id(in_id), .in_opcode(in_opcode), .in_payload(in_payload), .port_en(port_en),
        .out_valid(fp_out_valid), .out_ready(out_ready), .out_id(fp_out_id),
        .out_opcode(fp_out_opcode), .out_payload(fp_out_payload),
        .grant_idx(fp_grant_idx), .hs_count(fp_hs_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rr_beat(input string tag, input int k);
        chk({tag, "_valid"}, 32'(rr_out_valid), 32'd1);
        chk({tag, "_grant"}, 32'(rr_grant_idx), 32'(k));
        chk({tag, "_id"}, 32'(rr_out_id), 32'(e_id[k]));
        chk({tag, "_opcode"}, 32'(rr_out_opcode), 32'(e_op[k]));
        chk({tag, "_payload"}, 32'(rr_out_payload), 32'(e_pay[k]));
    endtask

    initial begin
        in_id      = {e_id[3], e_id[2], e_id[1], e_id[0]};
        in_opcode  = {e_op[3], e_op[2], e_op[1], e_op[0]};
        in_payload = {e_pay[3], e_pay[2], e_pay[1], e_pay[0]};
        rst        = 1'b0;
        in_valid   = 4'hF;
        port_en    = 4'hF;
        out_ready  = 1'b1;

        // Reset state, with requesters already valid.
        step();
        step();
        chk("rst_out_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_out_id", 32'(rr_out_id), 32'd0);
        chk("rst_out_opcode", 32'(rr_out_opcode), 32'd0);
        chk("rst_out_payload", 32'(rr_out_payload), 32'd0);
        chk("rst_grant_idx", 32'(rr_grant_idx), 32'd0);
        chk("rst_hs_count", 32'(rr_hs_count), 32'd0);
        chk("rst_in_ready", 32'(rr_in_ready), 32'd0);

        // Round-robin across all four ports.
        rst = 1'b1;
        #1;
        chk("rr_first_ready", 32'(rr_in_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_rr_beat("rr_seq", i % 4);
            chk("rr_seq_hs", 32'(rr_hs_count), 32'(i));
            chk("rr_seq_ready", 32'(rr_in_ready), 32'(1 << ((i + 1) % 4)));
            chk("fp_all_grant", 32'(fp_grant_idx), 32'd0);
        end
        step();
        chk("rr_hs_after8", 32'(rr_hs_count), 32'd8);
        chk("rr_grant_wrap", 32'(rr_grant_idx), 32'd0);

        // Port 2 beat held through a 10-cycle stall.
        in_valid = 4'b0100;
        step();
        chk_rr_beat("stall_load", 2);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready0", 32'(rr_in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_rr_beat("stall_hold", 2);
            chk("stall_ready", 32'(rr_in_ready), 32'd0);
            chk("stall_hs", 32'(rr_hs_count), 32'd9);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0000;
        step();
        chk("stall_release_hs", 32'(rr_hs_count), 32'd10);
        chk("drain_out_valid", 32'(rr_out_valid), 32'd0);

        // Port 2 disabled: order 0,1,3 repeating from a fresh pointer.
        rst = 1'b0;
        step();
        rst      = 1'b1;
        port_en  = 4'b1011;
        in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("en_ready_p2", 32'(rr_in_ready[2]), 32'd0);
            step();
            chk("en_grant", 32'(rr_grant_idx), (i % 3 == 2) ? 32'd3 : 32'(i % 3));
        end

        // Fixed priority: ports 1 and 3 contend, port 1 always wins.
        port_en  = 4'hF;
        in_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fp_ready", 32'(fp_in_ready), 32'b0010);
            step();
            chk("fp_grant", 32'(fp_grant_idx), 32'd1);
            chk("fp_id", 32'(fp_out_id), 32'(e_id[1]));
        end

        // hs_count wrap after 65536 handshakes.
        rst = 1'b0;
        step();
        rst      = 1'b1;
        in_valid = 4'hF;
        repeat (65535) @(posedge clk);
        step();
        chk("wrap_hs_ffff", 32'(rr_hs_count), 32'hFFFF);
        chk("wrap_grant", 32'(rr_grant_idx), 32'd3);
        step();
        chk("wrap_hs_zero", 32'(rr_hs_count), 32'h0000);
        step();
        chk("wrap_hs_one", 32'(rr_hs_count), 32'h0001);

        // Reset while stalled with a held beat; pointer sits at 2 beforehand.
        out_ready = 1'b0;
        step();
        chk_rr_beat("pre_rst_hold", 1);
        rst = 1'b0;
        step();
        chk("midrst_out_valid", 32'(rr_out_valid), 32'd0);
        chk("midrst_hs", 32'(rr_hs_count), 32'd0);
        chk("midrst_in_ready", 32'(rr_in_ready), 32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("postrst_ready", 32'(rr_in_ready), 32'h1);
        step();
        chk_rr_beat("postrst_grant", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
